cs_encoder_stream: RTL and testbench
====================================

Name: cs_encoder_stream

Overview:
- Sequential, handshaked successor to the combinational cyclic-shift network-coding encoder.
- Accepts one generation of M data symbols plus an N x M shift-coefficient matrix. Emits N coded symbols, one per cycle, over a valid/ready stream.
- N (coded outputs) is independent of M, which makes redundant coded packets possible.
- Sits between the source packetiser and the link framer.

Parameters:
- M, 3, source symbols per generation
- N, 4, coded symbols emitted per generation (N >= 1)
- WIDTH, 11, coded symbol width (extended ring length; prime in use)
- DATA_W, WIDTH-1, source data symbol width
- SH_W, $clog2(WIDTH), shift-amount field width
- CW, SH_W+1, coefficient width: {enable, shift}
- IDX_W, (N>1 ? $clog2(N) : 1), output row index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  generation offered
- in_ready  out  1  block can accept a generation
- in_data_flat  in  M*DATA_W  symbol c at [c*DATA_W +: DATA_W]
- in_coeff_flat  in  N*M*CW  coeff (r,c) at [(r*M+c)*CW +: CW]; MSB = enable, low SH_W bits = shift
- out_valid  out  1  coded symbol present
- out_ready  in  1  sink accepts
- out_symbol  out  WIDTH  coded symbol
- out_index  out  IDX_W  row r of out_symbol
- out_last  out  1  high with row N-1
- coeff_err  out  1  one-cycle pulse: accepted generation had an enabled shift >= WIDTH

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_symbol=0, out_index=0, out_last=0, coeff_err=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture data and coeffs into holding regs, then go to LOAD.
  - LOAD: in_ready=0. Register row 0 into the output regs, set out_valid=1 and out_index=0, then go to SEND.
  - SEND: in_ready=0, out_valid=1.
    - Handshake (out_valid & out_ready) with out_index < N-1: load row out_index+1 on the same edge. This gives full throughput, one row per cycle.
    - Handshake on row N-1: out_valid goes to 0 and the FSM returns to IDLE.
- Latency: acceptance edge t -> row 0 valid after edge t+1. Rows follow back-to-back under continuous out_ready.
- Backpressure: while out_valid & !out_ready, out_symbol, out_index and out_last hold stable.
- Symbol extension: ext_c = {^data_c, data_c}, i.e. the parity bit is the MSB; WIDTH bits total.
- Row compute: sym_r = XOR over c of (enable_rc ? rotl(ext_c, shift_rc) : 0). All-disabled row -> 0.
- Invalid shift: shift_rc >= WIDTH with enable=1 makes that term contribute 0. coeff_err pulses for one cycle during LOAD.
- Holding regs are stable for the whole generation; new input is ignored while in_ready=0.
- Last handshake and a new in_valid on the same edge: the new generation is not accepted. It is accepted on the next edge in IDLE (one-cycle bubble).
- Reset mid-generation: the generation is dropped and all outputs return to their reset values on the next edge.
- N=1: LOAD -> SEND with out_last=1 immediately.

Decomposition:
- Package cs_pkg holds:
  - coefficient field extraction (enable bit, shift field)
  - function rotl(sym, sh)
  - function extend(data) that appends the parity bit
- Sub-module cs_row_combiner: combinational. Inputs are M extended symbols and M coefficients; outputs are the WIDTH-bit row and an invalid-shift flag. One instance is fed by a row mux indexed by the next-row pointer.
- FSM, holding regs and output regs stay in cs_encoder_stream.

Test Plan (M=3, N=4, WIDTH=11):
- Identity/extension: data0=10'h001, data1=data2=0; row0 coeff0={1,0}, all others disabled -> row0=11'h401, rows1..3=0, out_last only on row 3.
- Rotation: data0=10'h001; row1 coeff0={1,1}; row2 coeff0={1,10} -> row1=11'h003, row2=rotl(11'h401,10)=11'h600.
- Combination: data0=10'h3FF, data1=10'h001, all enables on, shifts 0 -> row=11'h3FF ^ 11'h401 ^ 0 = 11'h7FE. Ext of 10'h3FF: parity 0 -> 11'h3FF.
- Backpressure: out_ready low for 5 cycles on row 1 -> out_symbol/out_index stable. Total handshakes = 4, in_ready=0 throughout, then 1 after row 3.
- Invalid shift: row2 coeff1={1,11} with data1=10'h001 -> that term contributes 0, coeff_err pulses once.
- Reset/back-to-back: assert rst during row 2 -> out_valid=0, in_ready=1 next cycle. Then two generations with in_valid held high -> second accepted exactly one cycle after the first generation's last handshake.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared types and helpers for the streaming cyclic-shift encoder.
// Helpers work on 32-bit containers with an explicit ring width so they serve any parameterisation.
package cs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } state_t;

  function automatic logic coeff_en(input logic [31:0] coeff, input int shw);
    return ((coeff >> shw) & 32'h1) != 32'h0;
  endfunction

  function automatic logic [31:0] coeff_shift(input logic [31:0] coeff, input int shw);
    return coeff & ((32'h1 << shw) - 32'h1);
  endfunction

  // Rotate the low w bits of sym left by sh (sh < w assumed by callers).
  function automatic logic [31:0] rotl(input logic [31:0] sym, input int sh, input int w);
    logic [31:0] mask;
    logic [31:0] s;
    mask = (32'h1 << w) - 32'h1;
    s    = sym & mask;
    return ((s << sh) | (s >> (w - sh))) & mask;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input int dw);
    logic [31:0] d;
    d = data & ((32'h1 << dw) - 32'h1);
    return d | (32'(^d) << dw);
  endfunction

endpackage

// File: rtl/cs_row_combiner.sv
// Combinational row of the encoder: XOR of the enabled, rotated extended symbols.
// Terms whose enabled shift falls outside the ring contribute nothing and raise o_bad_shift.
module cs_row_combiner
  import cs_pkg::*;
#(
  parameter int M     = 3,
  parameter int WIDTH = 11,
  parameter int SH_W  = $clog2(WIDTH),
  parameter int CW    = SH_W + 1
) (
  input  logic [M-1:0][WIDTH-1:0] i_ext,
  input  logic [M-1:0][CW-1:0]    i_coeff,
  output logic [WIDTH-1:0]        o_row,
  output logic                    o_bad_shift
);

  logic [31:0] w_shift;

  always_comb begin
    o_row       = '0;
    o_bad_shift = 1'b0;
    w_shift     = '0;
    for (int c = 0; c < M; c++) begin
      w_shift = coeff_shift(32'(i_coeff[c]), SH_W);
      if (coeff_en(32'(i_coeff[c]), SH_W)) begin
        if (w_shift >= 32'(WIDTH)) begin
          o_bad_shift = 1'b1;
        end else begin
          o_row = o_row ^ WIDTH'(rotl(32'(i_ext[c]), int'(w_shift), WIDTH));
        end
      end
    end
  end

endmodule

// File: rtl/cs_encoder_stream.sv
// Streaming cyclic-shift network-coding encoder: captures one generation, then emits
// N coded rows back-to-back over a valid/ready stream.
module cs_encoder_stream
  import cs_pkg::*;
#(
  parameter int M      = 3,
  parameter int N      = 4,
  parameter int WIDTH  = 11,
  parameter int DATA_W = WIDTH - 1,
  parameter int SH_W   = $clog2(WIDTH),
  parameter int CW     = SH_W + 1,
  parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [M*DATA_W-1:0]   in_data_flat,
  input  logic [N*M*CW-1:0]     in_coeff_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_symbol,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  coeff_err
);

  state_t r_state;
  state_t w_next_state;

  logic [M*DATA_W-1:0]   r_data;
  logic [N*M*CW-1:0]     r_coeff;
  logic [WIDTH-1:0]      r_symbol;
  logic [IDX_W-1:0]      r_index;
  logic                  r_last;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_done;
  logic                  w_handshake;
  logic [IDX_W-1:0]      w_sel;
  logic [M-1:0][WIDTH-1:0] w_ext;
  logic [M-1:0][CW-1:0]  w_row_coeff;
  logic [WIDTH-1:0]      w_row;
  logic                  w_row_bad;
  logic                  w_scan_bad;
  logic [31:0]           w_scan_shift;

  assign w_handshake = r_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (w_handshake) begin
          if (r_last) begin
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Row pointer: row 0 while loading, otherwise the row after the one on the bus.
  assign w_sel = (r_state == ST_SEND && r_index != IDX_W'(N - 1)) ?
                 r_index + IDX_W'(1) : '0;

  always_comb begin
    for (int c = 0; c < M; c++) begin
      w_ext[c] = WIDTH'(extend(32'(r_data[c*DATA_W +: DATA_W]), DATA_W));
    end
  end

  assign w_row_coeff = r_coeff[int'(w_sel)*M*CW +: M*CW];

  cs_row_combiner #(
    .M     (M),
    .WIDTH (WIDTH),
    .SH_W  (SH_W),
    .CW    (CW)
  ) u_row (
    .i_ext       (w_ext),
    .i_coeff     (w_row_coeff),
    .o_row       (w_row),
    .o_bad_shift (w_row_bad)
  );

  // Row 0 is checked by the combiner during LOAD; the remaining rows are scanned here.
  always_comb begin
    w_scan_bad   = 1'b0;
    w_scan_shift = '0;
    for (int r = 1; r < N; r++) begin
      for (int c = 0; c < M; c++) begin
        w_scan_shift = coeff_shift(32'(r_coeff[(r*M+c)*CW +: CW]), SH_W);
        if (coeff_en(32'(r_coeff[(r*M+c)*CW +: CW]), SH_W) &&
            w_scan_shift >= 32'(WIDTH)) begin
          w_scan_bad = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_coeff  <= '0;
      r_symbol <= '0;
      r_index  <= '0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= in_data_flat;
        r_coeff <= in_coeff_flat;
      end
      if (w_load) begin
        r_symbol <= w_row;
        r_index  <= w_sel;
        r_last   <= (w_sel == IDX_W'(N - 1));
        r_valid  <= 1'b1;
      end
      if (w_done) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_valid;
  assign out_symbol = r_symbol;
  assign out_index  = r_index;
  assign out_last   = r_last;
  assign coeff_err  = (r_state == ST_LOAD) & (w_row_bad | w_scan_bad);

endmodule

// File: tb/tb_cs_encoder_stream.sv
// Self-checking bench for cs_encoder_stream (M=3, N=4, WIDTH=11): directed cases
// followed by random generations, compared against a bit-level behavioural model.
module tb_cs_encoder_stream;

  localparam int M      = 3;
  localparam int N      = 4;
  localparam int WIDTH  = 11;
  localparam int DATA_W = 10;
  localparam int CW     = 5;
  localparam int IDX_W  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [M*DATA_W-1:0] in_data_flat;
  logic [N*M*CW-1:0]   in_coeff_flat;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_symbol;
  logic [IDX_W-1:0]    out_index;
  logic                out_last;
  logic                coeff_err;

  int vectors     = 0;
  int miscompares = 0;
  int hsCount     = 0;
  int hsBase;

  int tbData [M];
  int tbEn   [N][M];
  int tbSh   [N][M];
  int pendRow[N];
  int curRow [N];
  bit pendErr;
  bit curErr;

  always #5 clk = ~clk;

  cs_encoder_stream dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data_flat  (in_data_flat),
    .in_coeff_flat (in_coeff_flat),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_symbol    (out_symbol),
    .out_index     (out_index),
    .out_last      (out_last),
    .coeff_err     (coeff_err)
  );

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hsCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int extendModel(int d);
    int ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += (d >> i) & 1;
    return d + (ones % 2) * (1 << DATA_W);
  endfunction

  function automatic int rotlModel(int v, int s);
    int o = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (((v >> i) & 1) == 1) o = o | (1 << ((i + s) % WIDTH));
    end
    return o;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearGen();
    for (int c = 0; c < M; c++) tbData[c] = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) begin
        tbEn[r][c] = 0;
        tbSh[r][c] = 0;
      end
  endtask

  // Drive the flattened buses from the tables and compute the expected rows.
  task automatic applyStimulus();
    int acc;
    pendErr = 1'b0;
    for (int c = 0; c < M; c++) in_data_flat[c*DATA_W +: DATA_W] = DATA_W'(tbData[c]);
    for (int r = 0; r < N; r++) begin
      acc = 0;
      for (int c = 0; c < M; c++) begin
        in_coeff_flat[(r*M+c)*CW +: CW] = {1'(tbEn[r][c]), 4'(tbSh[r][c])};
        if (tbEn[r][c] != 0) begin
          if (tbSh[r][c] >= WIDTH) pendErr = 1'b1;
          else acc = acc ^ rotlModel(extendModel(tbData[c]), tbSh[r][c]);
        end
      end
      pendRow[r] = acc;
    end
  endtask

  task automatic acceptGen(bit keepValid);
    checkOutput("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (!keepValid) in_valid = 1'b0;
    curRow = pendRow;
    curErr = pendErr;
    checkOutput("load_in_ready", 32'(in_ready), 32'd0);
    checkOutput("load_out_valid", 32'(out_valid), 32'd0);
    checkOutput("load_coeff_err", 32'(coeff_err), 32'(curErr));
    @(posedge clk); #1;
  endtask

  task automatic checkRow(int r);
    checkOutput($sformatf("row%0d_valid", r), 32'(out_valid), 32'd1);
    checkOutput($sformatf("row%0d_symbol", r), 32'(out_symbol), 32'(curRow[r]));
    checkOutput($sformatf("row%0d_index", r), 32'(out_index), 32'(r));
    checkOutput($sformatf("row%0d_last", r), 32'(out_last), 32'(r == N - 1));
    checkOutput($sformatf("row%0d_in_ready", r), 32'(in_ready), 32'd0);
    checkOutput($sformatf("row%0d_coeff_err", r), 32'(coeff_err), 32'd0);
  endtask

  task automatic sendRows(int stallRow, int stallCycles);
    for (int r = 0; r < N; r++) begin
      checkRow(r);
      if (r == stallRow) begin
        out_ready = 1'b0;
        repeat (stallCycles) begin
          @(posedge clk); #1;
          checkRow(r);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    checkOutput("done_out_valid", 32'(out_valid), 32'd0);
    checkOutput("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    in_data_flat  = '0;
    in_coeff_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_symbol", 32'(out_symbol), 32'd0);
    checkOutput("rst_index", 32'(out_index), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_coeff_err", 32'(coeff_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity and parity extension.
    clearGen();
    tbData[0] = 10'h001;
    tbEn[0][0] = 1;
    applyStimulus();
    acceptGen(1'b0);
    checkOutput("identity_row0", 32'(out_symbol), 32'h401);
    sendRows(-1, 0);

    // Rotation by 1 and by WIDTH-1.
    clearGen();
    tbData[0] = 10'h001;
    tbEn[1][0] = 1; tbSh[1][0] = 1;
    tbEn[2][0] = 1; tbSh[2][0] = 10;
    applyStimulus();
    acceptGen(1'b0);
    sendRows(-1, 0);

    // Combination of all terms, with a 5-cycle stall on row 1.
    clearGen();
    tbData[0] = 10'h3FF;
    tbData[1] = 10'h001;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) tbEn[r][c] = 1;
    applyStimulus();
    hsBase = hsCount;
    acceptGen(1'b0);
    checkOutput("combo_row0", 32'(out_symbol), 32'h7FE);
    sendRows(1, 5);
    checkOutput("bp_handshakes", 32'(hsCount - hsBase), 32'd4);

    // Out-of-ring shift on row 2.
    clearGen();
    tbData[1] = 10'h001;
    tbEn[2][1] = 1; tbSh[2][1] = 11;
    tbEn[1][1] = 1; tbSh[1][1] = 3;
    applyStimulus();
    acceptGen(1'b0);
    sendRows(-1, 0);

    // Reset while row 2 is on the bus.
    clearGen();
    for (int c = 0; c < M; c++) tbData[c] = int'($urandom_range(1, 1023));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) begin
        tbEn[r][c] = 1;
        tbSh[r][c] = int'($urandom_range(0, 10));
      end
    applyStimulus();
    acceptGen(1'b0);
    checkRow(0);
    @(posedge clk); #1;
    checkRow(1);
    @(posedge clk); #1;
    checkRow(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_symbol", 32'(out_symbol), 32'd0);
    checkOutput("midrst_index", 32'(out_index), 32'd0);
    checkOutput("midrst_last", 32'(out_last), 32'd0);

    // Back-to-back generations with in_valid held; the second lands one cycle after the last handshake.
    clearGen();
    tbData[0] = 10'h155; tbData[2] = 10'h0F0;
    tbEn[0][0] = 1; tbEn[1][2] = 1; tbSh[1][2] = 4; tbEn[3][0] = 1; tbEn[3][2] = 1; tbSh[3][2] = 7;
    applyStimulus();
    acceptGen(1'b1);
    clearGen();
    tbData[1] = 10'h2AB;
    tbEn[0][1] = 1; tbSh[0][1] = 9; tbEn[2][1] = 1; tbSh[2][1] = 2; tbEn[3][1] = 1; tbSh[3][1] = 12;
    applyStimulus();
    sendRows(-1, 0);
    acceptGen(1'b0);
    sendRows(-1, 0);

    // Random generations with occasional stalls and out-of-ring shifts.
    for (int g = 0; g < 20; g++) begin
      for (int c = 0; c < M; c++) tbData[c] = int'($urandom_range(0, 1023));
      for (int r = 0; r < N; r++)
        for (int c = 0; c < M; c++) begin
          tbEn[r][c] = int'($urandom_range(0, 1));
          tbSh[r][c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 15))
                                                    : int'($urandom_range(0, 10));
        end
      applyStimulus();
      hsBase = hsCount;
      acceptGen(1'b0);
      sendRows(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
      checkOutput("rand_handshakes", 32'(hsCount - hsBase), 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
